// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle MULT/MULTU/DIV/DIVU engine that owns the HI/LO registers.
// The radix-2 core produces one result bit per cycle. Operands are reduced to their
// magnitudes at launch, and the sign is applied in a single fix-up cycle at the end.
module muldiv_unit #(
  parameter int unsigned ITER = 32
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        wr_hi,
  input  logic        wr_lo,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  localparam logic [5:0] LAST = 6'(ITER - 1);

  state_t      state;
  logic [5:0]  count;
  logic [1:0]  op_q;
  logic [31:0] ma, mb, a_raw;
  logic        res_neg, rem_neg;
  logic [63:0] acc;   // multiply accumulator {partial product, remaining multiplier}
  logic [32:0] rem;   // divide partial remainder
  logic [31:0] quo;   // dividend bits shift out as quotient bits shift in

  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum;
  logic [32:0] shifted;
  logic [33:0] diff;
  logic [31:0] fix_hi, fix_lo;

  // Operand magnitudes; signed ops take absolute values, unsigned ops pass through
  always_comb begin
    a_mag = (op[0] && a[31]) ? (~a + 32'd1) : a;
    b_mag = (op[0] && b[31]) ? (~b + 32'd1) : b;
  end

  // One iteration of shift-add multiply and restoring divide
  always_comb begin
    mul_sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, ma} : 33'd0);
    shifted = {rem[31:0], quo[31]};
    diff    = {1'b0, shifted} - {2'b00, mb};
  end

  // Sign correction and divide-by-zero result selection for the FIX cycle
  always_comb begin
    fix_hi = acc[63:32];
    fix_lo = acc[31:0];
    if (!op_q[1]) begin
      if (op_q[0] && res_neg) {fix_hi, fix_lo} = ~acc + 64'd1;
    end else if (mb == '0) begin
      fix_hi = a_raw;
      fix_lo = '1;
    end else begin
      fix_lo = (op_q[0] && res_neg) ? (~quo + 32'd1) : quo;
      fix_hi = (op_q[0] && rem_neg) ? (~rem[31:0] + 32'd1) : rem[31:0];
    end
  end

  // Control FSM, datapath registers and HI/LO
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state   <= IDLE;
      count   <= '0;
      op_q    <= '0;
      ma      <= '0;
      mb      <= '0;
      a_raw   <= '0;
      res_neg <= 1'b0;
      rem_neg <= 1'b0;
      acc     <= '0;
      rem     <= '0;
      quo     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_hi) hi <= wdata;
          if (wr_lo) lo <= wdata;
          if (start) begin
            op_q    <= op;
            ma      <= a_mag;
            mb      <= b_mag;
            a_raw   <= a;
            res_neg <= a[31] ^ b[31];
            rem_neg <= a[31];
            acc     <= {32'd0, b_mag};
            rem     <= '0;
            quo     <= a_mag;
            count   <= '0;
            busy    <= 1'b1;
            state   <= CALC;
          end
        end
        CALC: begin
          if (!op_q[1]) begin
            acc <= {mul_sum, acc[31:1]};
          end else if (!diff[33]) begin
            rem <= diff[32:0];
            quo <= {quo[30:0], 1'b1};
          end else begin
            rem <= shifted;
            quo <= {quo[30:0], 1'b0};
          end
          count <= count + 6'd1;
          if (count == LAST) state <= FIX;
        end
        FIX: begin
          hi    <= fix_hi;
          lo    <= fix_lo;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and randomized checks of muldiv_unit against a 64-bit arithmetic model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        clrn;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        wr_hi, wr_lo;
  logic [31:0] wdata;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_fail   = 0;

  muldiv_unit #(.ITER(32)) dut (
    .clk(clk), .clrn(clrn), .start(start), .op(op), .a(a), .b(b),
    .wr_hi(wr_hi), .wr_lo(wr_lo), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: {hi,lo} from plain 64-bit arithmetic
  function automatic logic [63:0] ref_model(input logic [1:0] op_i, input logic [31:0] a_i, b_i);
    longint sa, sb, q, r;
    logic [63:0] ua, ub, qv, rv;
    sa = $signed(a_i);
    sb = $signed(b_i);
    ua = {32'd0, a_i};
    ub = {32'd0, b_i};
    case (op_i)
      2'b00: return ua * ub;
      2'b01: return 64'(sa * sb);
      default: begin
        if (b_i == 32'd0) return {a_i, 32'hFFFF_FFFF};
        if (op_i == 2'b10) return {a_i % b_i, a_i / b_i};
        q = sa / sb;
        r = sa % sb;
        qv = q;
        rv = r;
        return {rv[31:0], qv[31:0]};
      end
    endcase
  endfunction

  // Launch one operation and follow it for 40 cycles. ps/wa: cycle of a stray start / MTLO (0 = none).
  task automatic run_op(input string tag, input logic [1:0] op_i, input logic [31:0] a_i, b_i,
                        input int ps, input int wa, input bit mthi);
    logic [63:0] expv;
    logic [31:0] hi0, lo0;
    int done_at, n_done, n_busy;
    bit stable;
    expv = ref_model(op_i, a_i, b_i);
    @(negedge clk);
    start = 1'b1; op = op_i; a = a_i; b = b_i;
    wr_hi = mthi; wdata = 32'hC3C3_0F0F;
    @(posedge clk); #1;
    start = 1'b0; wr_hi = 1'b0;
    check({tag, "_busy_e0"}, 64'(busy), 64'd1);
    if (mthi) check({tag, "_mthi_with_start"}, 64'(hi), 64'hC3C3_0F0F);
    hi0 = hi; lo0 = lo;
    n_busy = busy ? 1 : 0; n_done = 0; done_at = 0; stable = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == ps) begin start = 1'b1; op = ~op_i; a = $urandom; b = $urandom; end
      if (k == wa) begin wr_lo = 1'b1; wdata = 32'h5A5A_5A5A; end
      @(posedge clk); #1;
      start = 1'b0; wr_lo = 1'b0;
      if (busy) n_busy++;
      if (done) begin
        n_done++;
        if (done_at == 0) done_at = k;
      end
      if (k < 33 && (hi !== hi0 || lo !== lo0)) stable = 1'b0;
    end
    check({tag, "_latency"}, 64'(done_at), 64'd33);
    check({tag, "_done_pulses"}, 64'(n_done), 64'd1);
    check({tag, "_busy_cycles"}, 64'(n_busy), 64'd33);
    check({tag, "_hilo_stable"}, 64'(stable), 64'd1);
    check({tag, "_hi"}, 64'(hi), {32'd0, expv[63:32]});
    check({tag, "_lo"}, 64'(lo), {32'd0, expv[31:0]});
  endtask

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    int n_done;

    clrn = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
    wr_hi = 1'b0; wr_lo = 1'b0; wdata = '0;
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk); clrn = 1'b1;

    // MTHI / MTLO in IDLE
    @(negedge clk); wr_hi = 1'b1; wdata = 32'hA5A5_A5A5;
    @(posedge clk); #1; wr_hi = 1'b0;
    check("mthi", 64'(hi), 64'hA5A5_A5A5);
    @(negedge clk); wr_lo = 1'b1; wdata = 32'h1357_9BDF;
    @(posedge clk); #1; wr_lo = 1'b0;
    check("mtlo", 64'(lo), 64'h1357_9BDF);
    check("mtlo_hi_kept", 64'(hi), 64'hA5A5_A5A5);
    @(negedge clk); wr_hi = 1'b1; wr_lo = 1'b1; wdata = 32'h0BAD_F00D;
    @(posedge clk); #1; wr_hi = 1'b0; wr_lo = 1'b0;
    check("mthilo_hi", 64'(hi), 64'h0BAD_F00D);
    check("mthilo_lo", 64'(lo), 64'h0BAD_F00D);

    // Directed cases
    run_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 1'b0);
    check("multu_max_hi_const", 64'(hi), 64'hFFFF_FFFE);
    check("multu_max_lo_const", 64'(lo), 64'h0000_0001);
    run_op("mult_neg", 2'b01, 32'hFFFF_FFFD, 32'd5, 0, 0, 1'b0);
    check("mult_neg_lo_const", 64'(lo), 64'hFFFF_FFF1);
    run_op("div_neg", 2'b11, 32'hFFFF_FFF9, 32'd2, 0, 0, 1'b0);
    check("div_neg_lo_const", 64'(lo), 64'hFFFF_FFFD);
    check("div_neg_hi_const", 64'(hi), 64'hFFFF_FFFF);
    run_op("divu_100_7", 2'b10, 32'd100, 32'd7, 0, 0, 1'b0);
    check("divu_lo_const", 64'(lo), 64'h0000_000E);
    run_op("divu_by0", 2'b10, 32'h0000_1234, 32'd0, 0, 0, 1'b0);
    check("divu_by0_hi_const", 64'(hi), 64'h0000_1234);
    run_op("div_by0_neg", 2'b11, 32'hFFFF_FF00, 32'd0, 0, 0, 1'b0);
    run_op("div_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 1'b0);
    check("div_ovf_lo_const", 64'(lo), 64'h8000_0000);
    run_op("div_neg_divisor", 2'b11, 32'd7, 32'hFFFF_FFFE, 0, 0, 1'b0);
    run_op("disturb", 2'b00, 32'h0001_2345, 32'h0006_789A, 5, 10, 1'b0);
    run_op("mthi_start", 2'b01, 32'h8000_0000, 32'h8000_0000, 0, 0, 1'b1);

    // Randomized operations
    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = (i % 7 == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 3))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 15));
        2: rb = 32'd0 - 32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      run_op($sformatf("rnd%0d", i), rop, ra, rb, 0, 0, 1'b0);
    end

    // Reset mid-operation aborts without a result
    @(negedge clk); wr_hi = 1'b1; wr_lo = 1'b1; wdata = 32'hDEAD_BEEF;
    @(posedge clk); #1; wr_hi = 1'b0; wr_lo = 1'b0;
    @(negedge clk); start = 1'b1; op = 2'b11; a = 32'd1000; b = 32'd3;
    @(posedge clk); #1; start = 1'b0;
    repeat (20) @(posedge clk);
    #2; clrn = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_hi", 64'(hi), 64'd0);
    check("abort_lo", 64'(lo), 64'd0);
    @(negedge clk); clrn = 1'b1;
    n_done = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done) n_done++;
    end
    check("abort_no_done", 64'(n_done), 64'd0);
    check("abort_idle_busy", 64'(busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
